mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (fetch/data) arbiter onto one single-port memory with timeout abort
module mem_arbiter #(
  parameter int RR = 1,
  parameter int TO = 15
) (
  input  logic        inclk,
  input  logic        rstn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_done,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        m_cs,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ready,
  output logic        busy,
  output logic        err
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;
  localparam logic [7:0] CNT_LAST = 8'(TO - 1);

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        i_done_q, i_done_d;
  logic        d_done_q, d_done_d;
  logic        err_q, err_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic        i_elig, d_elig;
  logic        grant;
  logic        grant_owner;

  // A port still showing its done pulse is dropping its request this cycle.
  assign i_elig = i_req && !i_done_q;
  assign d_elig = d_req && !d_done_q;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
    err_d       = 1'b0;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    grant       = 1'b0;
    grant_owner = OWN_I;

    case (state_q)
      IDLE: begin
        if (i_elig || d_elig) begin
          grant = 1'b1;
          if (i_elig && d_elig) begin
            grant_owner = (RR != 0) ? ~last_q : OWN_D;
          end else begin
            grant_owner = d_elig;
          end
        end
      end
      ACCESS: begin
        if (m_ready) begin
          if (!we_q) begin
            if (owner_q == OWN_D) d_rdata_d = m_rdata;
            else                  i_rdata_d = m_rdata;
          end
          if (owner_q == OWN_D) d_done_d = 1'b1;
          else                  i_done_d = 1'b1;
          last_d  = owner_q;
          state_d = IDLE;
          // Hand the memory straight to a waiting other port so there is no idle bubble.
          if ((owner_q == OWN_D) ? i_elig : d_elig) begin
            grant       = 1'b1;
            grant_owner = ~owner_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          if (owner_q == OWN_D) d_done_d = 1'b1;
          else                  i_done_d = 1'b1;
          err_d   = 1'b1;
          last_d  = owner_q;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (grant) begin
      state_d = ACCESS;
      owner_d = grant_owner;
      cnt_d   = 8'd0;
      if (grant_owner == OWN_D) begin
        we_d    = d_we;
        addr_d  = d_addr;
        wdata_d = d_wdata;
      end else begin
        we_d    = 1'b0;
        addr_d  = i_addr;
        wdata_d = 32'd0;
      end
    end
  end

  always_ff @(posedge inclk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      last_q    <= OWN_I;
      cnt_q     <= 8'd0;
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      i_done_q  <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      i_done_q  <= i_done_d;
      d_done_q  <= d_done_d;
      err_q     <= err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign busy    = (state_q == ACCESS);
  assign m_cs    = busy;
  assign m_we    = busy ? we_q : 1'b0;
  assign m_addr  = busy ? addr_q : 32'd0;
  assign m_wdata = busy ? wdata_q : 32'd0;
  assign i_done  = i_done_q;
  assign d_done  = d_done_q;
  assign err     = err_q;
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed scoreboard bench for mem_arbiter with a wait-state memory model
module tb_mem_arbiter;

  localparam logic [31:0] RD_OFS = 32'h2007_D005;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic        err;
  } done_t;

  logic        inclk, rstn;
  logic        i_req, i_done;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_done;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_cs, m_we, m_ready;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        busy, err;

  logic        i_req0, d_req0;
  logic [31:0] i_addr0, d_addr0;
  logic        i_done0, d_done0, m_cs0, m_we0, busy0, err0;
  logic [31:0] i_rdata0, d_rdata0, m_addr0, m_wdata0;

  int n_cmp = 0;
  int n_bad = 0;
  cmd_t  cmd_q[$];
  done_t done_q[$];
  logic [31:0] model_i_rdata, model_d_rdata;
  int   wait_cycles;
  logic hold_off;
  logic prev_cs;
  int   wcnt;

  mem_arbiter #(.RR(1), .TO(4)) u_dut (
    .inclk(inclk), .rstn(rstn),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .m_cs(m_cs), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy), .err(err)
  );

  mem_arbiter #(.RR(0), .TO(4)) u_dut0 (
    .inclk(inclk), .rstn(rstn),
    .i_req(i_req0), .i_addr(i_addr0), .i_done(i_done0), .i_rdata(i_rdata0),
    .d_req(d_req0), .d_we(1'b0), .d_addr(d_addr0), .d_wdata(32'd0),
    .d_done(d_done0), .d_rdata(d_rdata0),
    .m_cs(m_cs0), .m_we(m_we0), .m_addr(m_addr0), .m_wdata(m_wdata0),
    .m_rdata(32'h0000_1234), .m_ready(1'b1), .busy(busy0), .err(err0)
  );

  initial begin
    inclk = 1'b0;
    forever #5 inclk = ~inclk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0b required %0b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge inclk);
  endtask

  task automatic push(input logic port, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic e);
    cmd_t  c;
    done_t d;
    c.we = we; c.addr = addr; c.wdata = wdata;
    d.port = port; d.we = we; d.addr = addr; d.err = e;
    cmd_q.push_back(c);
    done_q.push_back(d);
  endtask

  // Memory responder plus scoreboard monitor, evaluated once per falling edge.
  initial begin
    m_ready = 1'b0;
    m_rdata = 32'd0;
    prev_cs = 1'b0;
    wcnt    = 0;
    forever begin
      @(negedge inclk);
      if (m_cs && (!prev_cs || m_ready)) begin
        chk1("cmd_pending", cmd_q.size() != 0, 1'b1);
        if (cmd_q.size() != 0) begin
          cmd_t c;
          c = cmd_q.pop_front();
          chk("cmd_addr", m_addr, c.addr);
          chk1("cmd_we", m_we, c.we);
          if (c.we) chk("cmd_wdata", m_wdata, c.wdata);
        end
      end
      if (i_done || d_done) begin
        chk1("done_pending", done_q.size() != 0, 1'b1);
        if (done_q.size() != 0) begin
          done_t d;
          d = done_q.pop_front();
          chk1("done_port", d_done, d.port);
          chk1("done_err", err, d.err);
          if (!d.err && !d.we) begin
            if (d.port) model_d_rdata = d.addr + RD_OFS;
            else        model_i_rdata = d.addr + RD_OFS;
          end
          chk("i_rdata", i_rdata, model_i_rdata);
          chk("d_rdata", d_rdata, model_d_rdata);
        end
      end
      prev_cs = m_cs;
      if (m_cs && !hold_off && wcnt >= wait_cycles) begin
        m_ready = 1'b1;
        m_rdata = m_addr + RD_OFS;
        wcnt    = 0;
      end else begin
        m_ready = 1'b0;
        wcnt    = m_cs ? wcnt + 1 : 0;
      end
    end
  end

  // Requesters raise req, hold it until done, drop it in the done cycle.
  task automatic serve(input int n_i, input int n_d, input logic [31:0] i_base,
                       input logic [31:0] d_base, input int max_cyc);
    int i_iss = 0, d_iss = 0, i_fin = 0, d_fin = 0;
    int cyc = 0;
    d_we = 1'b0;
    while (cyc < max_cyc && !(i_fin == n_i && d_fin == n_d)) begin
      if (i_done) begin
        i_req = 1'b0; i_fin++;
      end else if (!i_req && i_iss < n_i) begin
        i_req = 1'b1; i_addr = i_base + 32'(4 * i_iss); i_iss++;
      end
      if (d_done) begin
        d_req = 1'b0; d_fin++;
      end else if (!d_req && d_iss < n_d) begin
        d_req = 1'b1; d_addr = d_base + 32'(4 * d_iss); d_iss++;
      end
      tick();
      chk1("done_excl", i_done & d_done, 1'b0);
      cyc++;
    end
    chk1("serve_in_budget", (i_fin == n_i) && (d_fin == n_d), 1'b1);
    i_req = 1'b0;
    d_req = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    model_i_rdata = 32'd0;
    model_d_rdata = 32'd0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    i_req = 1'b0; i_addr = 32'd0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'd0; d_wdata = 32'd0;
    i_req0 = 1'b0; i_addr0 = 32'd0; d_req0 = 1'b0; d_addr0 = 32'd0;
    wait_cycles = 0;
    hold_off = 1'b0;
    model_i_rdata = 32'd0;
    model_d_rdata = 32'd0;
    tick();
    tick();
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_m_cs", m_cs, 1'b0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk1("rst_i_done", i_done, 1'b0);
    chk1("rst_d_done", d_done, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    rstn = 1'b1;
    tick();

    // single fetch, zero wait states
    i_req = 1'b1; i_addr = 32'h0000_3000;
    push(1'b0, 1'b0, 32'h0000_3000, 32'd0, 1'b0);
    tick();
    chk1("f_m_cs", m_cs, 1'b1);
    chk1("f_m_we", m_we, 1'b0);
    chk("f_m_addr", m_addr, 32'h0000_3000);
    chk1("f_busy", busy, 1'b1);
    tick();
    chk1("f_m_cs_drop", m_cs, 1'b0);
    chk1("f_i_done", i_done, 1'b1);
    chk("f_i_rdata", i_rdata, 32'h2008_0005);
    i_req = 1'b0;
    tick();
    chk1("f_i_done_pulse", i_done, 1'b0);
    chk1("f_no_reissue", m_cs, 1'b0);

    // store with three wait states
    wait_cycles = 3;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0010; d_wdata = 32'hDEAD_BEEF;
    push(1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("s_m_addr", m_addr, 32'h0000_0010);
      chk("s_m_wdata", m_wdata, 32'hDEAD_BEEF);
      chk1("s_m_we", m_we, 1'b1);
      chk1("s_no_done", d_done, 1'b0);
    end
    tick();
    chk1("s_d_done", d_done, 1'b1);
    chk("s_d_rdata", d_rdata, 32'd0);
    chk1("s_busy", busy, 1'b0);
    d_req = 1'b0; d_we = 1'b0; d_wdata = 32'd0;
    wait_cycles = 0;
    tick();

    // round-robin tie from reset: D, I, D, I
    do_reset();
    push(1'b1, 1'b0, 32'h0000_0100, 32'd0, 1'b0);
    push(1'b0, 1'b0, 32'h0000_0200, 32'd0, 1'b0);
    push(1'b1, 1'b0, 32'h0000_0104, 32'd0, 1'b0);
    push(1'b0, 1'b0, 32'h0000_0204, 32'd0, 1'b0);
    serve(2, 2, 32'h0000_0200, 32'h0000_0100, 40);
    tick();

    // timeout with TO=4, then a fresh fetch is granted
    hold_off = 1'b1;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0040;
    push(1'b1, 1'b0, 32'h0000_0040, 32'd0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk1("t_busy", busy, 1'b1);
      chk1("t_no_done", d_done, 1'b0);
    end
    tick();
    chk1("t_d_done", d_done, 1'b1);
    chk1("t_err", err, 1'b1);
    chk1("t_busy_fall", busy, 1'b0);
    d_req = 1'b0;
    hold_off = 1'b0;
    i_req = 1'b1; i_addr = 32'h0000_0300;
    push(1'b0, 1'b0, 32'h0000_0300, 32'd0, 1'b0);
    tick();
    chk1("t_next_cs", m_cs, 1'b1);
    chk("t_next_addr", m_addr, 32'h0000_0300);
    chk1("t_err_pulse", err, 1'b0);
    tick();
    chk1("t_next_done", i_done, 1'b1);
    i_req = 1'b0;
    tick();

    // reset during an access aborts it silently
    hold_off = 1'b1;
    d_req = 1'b1; d_addr = 32'h0000_0050;
    begin
      cmd_t c;
      c.we = 1'b0; c.addr = 32'h0000_0050; c.wdata = 32'd0;
      cmd_q.push_back(c);
    end
    tick();
    chk1("r_busy", busy, 1'b1);
    tick();
    rstn = 1'b0;
    d_req = 1'b0;
    model_i_rdata = 32'd0;
    model_d_rdata = 32'd0;
    tick();
    chk1("r_m_cs", m_cs, 1'b0);
    chk1("r_busy_low", busy, 1'b0);
    chk1("r_no_done", d_done, 1'b0);
    chk1("r_no_err", err, 1'b0);
    rstn = 1'b1;
    hold_off = 1'b0;
    tick();
    chk1("r_no_late_done", d_done | i_done, 1'b0);
    push(1'b1, 1'b0, 32'h0000_0060, 32'd0, 1'b0);
    push(1'b0, 1'b0, 32'h0000_0070, 32'd0, 1'b0);
    serve(1, 1, 32'h0000_0070, 32'h0000_0060, 20);
    tick();

    // fixed priority instance: D wins a tie even right after D was served
    d_req0 = 1'b1; d_addr0 = 32'h0000_00A0;
    tick();
    chk("p_first", m_addr0, 32'h0000_00A0);
    tick();
    chk1("p_d_done", d_done0, 1'b1);
    d_req0 = 1'b0;
    tick();
    d_req0 = 1'b1; d_addr0 = 32'h0000_00A4;
    i_req0 = 1'b1; i_addr0 = 32'h0000_00B0;
    tick();
    chk("p_tie_d", m_addr0, 32'h0000_00A4);
    tick();
    chk("p_chain_i", m_addr0, 32'h0000_00B0);
    d_req0 = 1'b0;
    tick();
    i_req0 = 1'b0;
    tick();

    chk("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
    chk("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
